fetch_unit: RTL and testbench

Instruction-fetch stage sitting directly downstream of the PC register. It takes the current PC (and the PC register's next-value input), drives a req/ack instruction-memory port, and loads the IF/ID pipeline register. It also produces `pc_advance_o`, the load-enable for the PC register, and handles ID-stage stalls and branch/jump flushes, including discarding in-flight memory responses.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_unit_flopenrc.sv | 26 ++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam int unsigned PC_INC    = 4;

endpackage

// File: rtl/fetch_unit_flopenrc.sv
// Async-reset register with load enable and synchronous clear back to INIT.
module flopenrc #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= INIT;
        end else if (en) begin
            if (clr) begin
                q <= INIT;
            end else begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: req/ack memory port, PC load-enable, IF/ID register
// with stall hold and flush kill, including discard of in-flight responses.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W    = 9,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc_i,
    input  logic [PC_W-1:0]    pc_next_i,
    output logic               pc_advance_o,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               id_stall_i,
    input  logic               flush_i,
    output logic               if_id_valid_o,
    output logic [INSTR_W-1:0] if_id_instr_o,
    output logic [PC_W-1:0]    if_id_pc_o,
    output logic [PC_W-1:0]    if_id_pc4_o
);

    localparam logic [INSTR_W-1:0] NOP = INSTR_W'(INSTR_NOP);

    fetch_state_t state, state_next;
    logic [PC_W-1:0]    addr_q;
    logic               accept_req, accept_hold, accept, hold_load;
    logic               ifid_en, ifid_clr;
    logic [INSTR_W-1:0] hold_instr, load_instr;
    logic [PC_W-1:0]    hold_pc, load_pc, load_pc4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: state_next = flush_i ? IDLE : REQ;
            REQ: begin
                if (imem_ack_i) begin
                    if (flush_i)         state_next = IDLE;
                    else if (id_stall_i) state_next = HOLD;
                    else                 state_next = REQ;
                end else if (flush_i) begin
                    state_next = DROP;
                end
            end
            DROP: state_next = imem_ack_i ? IDLE : DROP;
            HOLD: begin
                if (flush_i)          state_next = IDLE;
                else if (!id_stall_i) state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_req_o  = 1'b0;
        accept_req  = 1'b0;
        accept_hold = 1'b0;
        hold_load   = 1'b0;
        unique case (state)
            REQ: begin
                imem_req_o = 1'b1;
                accept_req = imem_ack_i && !flush_i && !id_stall_i;
                hold_load  = imem_ack_i && !flush_i && id_stall_i;
            end
            DROP:    imem_req_o  = 1'b1;
            HOLD:    accept_hold = !flush_i && !id_stall_i;
            default: ;
        endcase
    end

    assign accept       = accept_req || accept_hold;
    assign pc_advance_o = accept;
    assign imem_addr_o  = addr_q;

    // addr_q follows the PC register: sampled in IDLE, stepped on every accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
        end else if (state == IDLE) begin
            addr_q <= pc_i;
        end else if (accept) begin
            addr_q <= pc_next_i;
        end
    end

    flopenrc #(.WIDTH(INSTR_W), .INIT('0)) u_hold_instr (
        .clk(clk), .reset(reset), .en(hold_load), .clr(1'b0),
        .d(imem_rdata_i), .q(hold_instr)
    );

    flopenrc #(.WIDTH(PC_W), .INIT('0)) u_hold_pc (
        .clk(clk), .reset(reset), .en(hold_load), .clr(1'b0),
        .d(addr_q), .q(hold_pc)
    );

    // Flush wins over stall; anything not stalled and not accepted is a bubble.
    assign ifid_en    = flush_i || !id_stall_i;
    assign ifid_clr   = flush_i || !accept;
    assign load_instr = accept_hold ? hold_instr : imem_rdata_i;
    assign load_pc    = accept_hold ? hold_pc : addr_q;
    assign load_pc4   = load_pc + PC_W'(PC_INC);

    flopenrc #(.WIDTH(1), .INIT(1'b0)) u_ifid_valid (
        .clk(clk), .reset(reset), .en(ifid_en), .clr(ifid_clr),
        .d(1'b1), .q(if_id_valid_o)
    );

    flopenrc #(.WIDTH(INSTR_W), .INIT(NOP)) u_ifid_instr (
        .clk(clk), .reset(reset), .en(ifid_en), .clr(ifid_clr),
        .d(load_instr), .q(if_id_instr_o)
    );

    flopenrc #(.WIDTH(PC_W), .INIT('0)) u_ifid_pc (
        .clk(clk), .reset(reset), .en(ifid_en), .clr(ifid_clr),
        .d(load_pc), .q(if_id_pc_o)
    );

    flopenrc #(.WIDTH(PC_W), .INIT('0)) u_ifid_pc4 (
        .clk(clk), .reset(reset), .en(ifid_en), .clr(ifid_clr),
        .d(load_pc4), .q(if_id_pc4_o)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit against a transaction-level
// model of the PC register, the memory and the IF/ID contents.
module tb_fetch_unit;

    localparam int PC_W    = 9;
    localparam int INSTR_W = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic               clk = 1'b0;
    logic               reset;
    logic [PC_W-1:0]    pc_i, pc_next_i;
    logic               pc_advance_o;
    logic               imem_req_o;
    logic [PC_W-1:0]    imem_addr_o;
    logic               imem_ack_i;
    logic [INSTR_W-1:0] imem_rdata_i;
    logic               id_stall_i, flush_i;
    logic               if_id_valid_o;
    logic [INSTR_W-1:0] if_id_instr_o;
    logic [PC_W-1:0]    if_id_pc_o, if_id_pc4_o;

    always #5 clk = ~clk;

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk(clk), .reset(reset),
        .pc_i(pc_i), .pc_next_i(pc_next_i), .pc_advance_o(pc_advance_o),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .id_stall_i(id_stall_i), .flush_i(flush_i),
        .if_id_valid_o(if_id_valid_o), .if_id_instr_o(if_id_instr_o),
        .if_id_pc_o(if_id_pc_o), .if_id_pc4_o(if_id_pc4_o)
    );

    int checks = 0;
    int errors = 0;

    // Model: PC register, outstanding-response bookkeeping, expected IF/ID.
    logic [PC_W-1:0] m_pc;
    bit              m_stale, m_avail, m_idle;
    logic            m_valid;
    logic [31:0]     m_instr;
    logic [PC_W-1:0] m_ipc, m_ipc4;
    int              mem_cnt, mem_lat;
    bit              rand_lat;
    bit              prev_wait;
    logic [PC_W-1:0] prev_addr;

    logic            s_req, s_adv, s_valid;
    logic [PC_W-1:0] s_addr, s_pc, s_pc4;
    logic [31:0]     s_instr;

    function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
        return 32'h0010_0093 ^ ({23'd0, a} << 12);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic initModel();
        m_pc      = '0;
        m_stale   = 1'b0;
        m_avail   = 1'b0;
        m_idle    = 1'b1;
        m_valid   = 1'b0;
        m_instr   = NOP;
        m_ipc     = '0;
        m_ipc4    = '0;
        mem_cnt   = 0;
        prev_wait = 1'b0;
        prev_addr = '0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic applyStimulus(input bit st, input bit fl, input logic [PC_W-1:0] target);
        bit fresh, exp_req, exp_adv, stale_n;
        id_stall_i   = st;
        flush_i      = fl;
        pc_i         = m_pc;
        pc_next_i    = m_pc + 9'd4;
        imem_ack_i   = imem_req_o && (mem_cnt >= mem_lat - 1);
        imem_rdata_i = imem_ack_i ? mem_word(imem_addr_o) : 32'hDEAD_BEEF;
        #4;
        s_req   = imem_req_o;
        s_addr  = imem_addr_o;
        s_adv   = pc_advance_o;
        s_valid = if_id_valid_o;
        s_instr = if_id_instr_o;
        s_pc    = if_id_pc_o;
        s_pc4   = if_id_pc4_o;

        fresh   = imem_ack_i && !m_stale;
        exp_req = m_stale ? 1'b1 : ((m_idle || m_avail) ? 1'b0 : 1'b1);
        exp_adv = !fl && !st && (m_avail || fresh);

        checkOutput("req", 32'(s_req), 32'(exp_req));
        checkOutput("advance", 32'(s_adv), 32'(exp_adv));
        checkOutput("ifid_valid", 32'(s_valid), 32'(m_valid));
        checkOutput("ifid_instr", s_instr, m_instr);
        if (m_valid) begin
            checkOutput("ifid_pc", 32'(s_pc), 32'(m_ipc));
            checkOutput("ifid_pc4", 32'(s_pc4), 32'(m_ipc4));
        end
        if (fresh) checkOutput("fetch_addr", 32'(s_addr), 32'(m_pc));
        if (prev_wait) checkOutput("addr_stable", 32'(s_addr), 32'(prev_addr));

        stale_n = (m_stale && !imem_ack_i) || (fl && exp_req && !imem_ack_i);
        m_idle  = (fl && !stale_n) || (m_stale && imem_ack_i);
        m_avail = !fl && (m_avail || fresh) && !exp_adv;
        m_stale = stale_n;
        if (fl) begin
            m_valid = 1'b0;
            m_instr = NOP;
        end else if (!st) begin
            if (exp_adv) begin
                m_valid = 1'b1;
                m_instr = mem_word(m_pc);
                m_ipc   = m_pc;
                m_ipc4  = m_pc + 9'd4;
            end else begin
                m_valid = 1'b0;
                m_instr = NOP;
            end
        end
        if (fl)           m_pc = target;
        else if (exp_adv) m_pc = m_pc + 9'd4;

        prev_wait = s_req && !imem_ack_i;
        prev_addr = s_addr;
        if (s_req && imem_ack_i) begin
            mem_cnt = 0;
            if (rand_lat) mem_lat = int'($urandom_range(1, 3));
        end else if (s_req) begin
            mem_cnt++;
        end
        @(negedge clk);
    endtask

    // Reset is raised mid-cycle to exercise the asynchronous clear.
    task automatic doReset();
        #2;
        reset        = 1'b1;
        id_stall_i   = 1'b0;
        flush_i      = 1'b0;
        imem_ack_i   = 1'b0;
        imem_rdata_i = 32'hDEAD_BEEF;
        pc_i         = '0;
        pc_next_i    = 9'd4;
        #1;
        checkOutput("rst_req", 32'(imem_req_o), 32'd0);
        checkOutput("rst_adv", 32'(pc_advance_o), 32'd0);
        checkOutput("rst_valid", 32'(if_id_valid_o), 32'd0);
        checkOutput("rst_instr", if_id_instr_o, NOP);
        checkOutput("rst_pc", 32'(if_id_pc_o), 32'd0);
        checkOutput("rst_pc4", 32'(if_id_pc4_o), 32'd0);
        initModel();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n_adv, n_bub;
        logic [PC_W-1:0] tgt;
        bit st, fl;

        reset    = 1'b1;
        rand_lat = 1'b0;
        mem_lat  = 1;
        initModel();
        @(negedge clk);

        $display("[TB] zero-wait fetch after reset");
        doReset();
        applyStimulus(0, 0, '0);
        checkOutput("A_c0_req", 32'(s_req), 32'd0);
        applyStimulus(0, 0, '0);
        checkOutput("A_c1_req", 32'(s_req), 32'd1);
        checkOutput("A_c1_addr", 32'(s_addr), 32'd0);
        checkOutput("A_c1_adv", 32'(s_adv), 32'd1);
        applyStimulus(0, 0, '0);
        checkOutput("A_c2_valid", 32'(s_valid), 32'd1);
        checkOutput("A_c2_instr", s_instr, 32'h0010_0093);
        checkOutput("A_c2_pc", 32'(s_pc), 32'd0);
        checkOutput("A_c2_pc4", 32'(s_pc4), 32'd4);
        checkOutput("A_c2_adv", 32'(s_adv), 32'd1);
        applyStimulus(0, 0, '0);
        checkOutput("A_c3_adv", 32'(s_adv), 32'd1);
        checkOutput("A_c3_pc", 32'(s_pc), 32'd4);

        $display("[TB] 3-cycle memory latency");
        mem_lat = 3;
        n_adv = 0;
        n_bub = 0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 0, '0);
            if (s_adv) n_adv++;
            if (!s_valid && s_instr === NOP) n_bub++;
        end
        checkOutput("B_adv_count", 32'(n_adv), 32'd3);
        checkOutput("B_bubbles", 32'(n_bub), 32'd6);
        mem_lat = 1;

        $display("[TB] stall at ack");
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0);
        applyStimulus(1, 0, '0);
        checkOutput("C_ack_addr", 32'(s_addr), 32'd8);
        checkOutput("C_ack_adv", 32'(s_adv), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, '0);
            checkOutput("C_stall_adv", 32'(s_adv), 32'd0);
        end
        applyStimulus(0, 0, '0);
        checkOutput("C_release_adv", 32'(s_adv), 32'd1);
        applyStimulus(0, 0, '0);
        checkOutput("C_valid", 32'(s_valid), 32'd1);
        checkOutput("C_pc", 32'(s_pc), 32'd8);
        checkOutput("C_next_addr", 32'(s_addr), 32'd12);

        $display("[TB] flush while waiting");
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, '0);
        mem_lat = 3;
        applyStimulus(0, 1, 9'd64);
        checkOutput("D_flush_addr", 32'(s_addr), 32'd16);
        checkOutput("D_flush_adv", 32'(s_adv), 32'd0);
        applyStimulus(0, 0, '0);
        checkOutput("D_drop_valid", 32'(s_valid), 32'd0);
        applyStimulus(0, 0, '0);
        checkOutput("D_stale_adv", 32'(s_adv), 32'd0);
        mem_lat = 1;
        applyStimulus(0, 0, '0);
        checkOutput("D_idle_req", 32'(s_req), 32'd0);
        applyStimulus(0, 0, '0);
        checkOutput("D_target_req", 32'(s_req), 32'd1);
        checkOutput("D_target_addr", 32'(s_addr), 32'd64);
        applyStimulus(0, 0, '0);
        checkOutput("D_target_pc", 32'(s_pc), 32'd64);

        $display("[TB] simultaneous ack, flush and stall");
        applyStimulus(1, 1, 9'd128);
        checkOutput("E_adv", 32'(s_adv), 32'd0);
        applyStimulus(0, 0, '0);
        checkOutput("E_valid", 32'(s_valid), 32'd0);
        checkOutput("E_idle_req", 32'(s_req), 32'd0);
        applyStimulus(0, 0, '0);
        checkOutput("E_target_addr", 32'(s_addr), 32'd128);

        $display("[TB] PC wrap-around");
        applyStimulus(0, 1, 9'd508);
        applyStimulus(0, 0, '0);
        applyStimulus(0, 0, '0);
        checkOutput("F_req_addr", 32'(s_addr), 32'd508);
        applyStimulus(0, 0, '0);
        checkOutput("F_pc", 32'(s_pc), 32'd508);
        checkOutput("F_pc4", 32'(s_pc4), 32'd0);
        checkOutput("F_wrap_addr", 32'(s_addr), 32'd0);

        $display("[TB] randomized traffic");
        doReset();
        rand_lat = 1'b1;
        for (int i = 0; i < 800; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 11) == 0);
            tgt = 9'($urandom_range(0, 127) * 4);
            for (int k = 0; k < 3; k++) begin
                if (tgt == m_pc || tgt == imem_addr_o) tgt = tgt + 9'd4;
            end
            applyStimulus(st, fl, tgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
